rdata_chan_subo_burst: RTL and testbench
========================================

RDATA_CHAN_SUBO_BURST -- requirements
Module: rdata_chan_subo_burst

Interface
REQ-001 SHALL have parameter DW, default 32: read data bus width in bits.
REQ-002 SHALL have parameter BEATS, default 4: maximum beats per burst; power of 2, at least 2.
REQ-003 SHALL have parameter IDW, default 4: ID width.
REQ-004 SHALL have parameter QDEPTH, default 2: response queue depth; at least 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic samples on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port rvalid, output, 1 bit: read beat valid.
REQ-008 SHALL have port rready, input, 1 bit: manager accepts the beat.
REQ-009 SHALL have port rid, output, IDW bits: ID of the current burst.
REQ-010 SHALL have port rdata, output, DW bits: current beat data.
REQ-011 SHALL have port rresp, output, 2 bits: response code of the current burst, the same on every beat.
REQ-012 SHALL have port rlast, output, 1 bit: final beat of the burst.
REQ-013 SHALL have port rdata_s_valid, input, 1 bit: source offers a line.
REQ-014 SHALL have port rdata_s_ready, output, 1 bit: block accepts the line.
REQ-015 SHALL have port rdata_s_id, input, IDW bits: ID of the offered line.
REQ-016 SHALL have port rdata_s_data, input, DW*BEATS bits: line data; beat k is bits [k*DW +: DW].
REQ-017 SHALL have port rdata_s_len, input, log2(BEATS) bits: number of beats minus 1.
REQ-018 SHALL have port rdata_s_resp, input, 2 bits: response code of the offered line.
REQ-019 SHALL have port finish_rdata_s, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-020 Push SHALL occur when rdata_s_valid and rdata_s_ready are both high; push stores {id, data, len, resp} at the queue tail.
REQ-021 rdata_s_ready SHALL equal (entry count < QDEPTH) and SHALL NOT depend combinationally on rready.
REQ-022 Beat handshake SHALL occur when rvalid and rready are both high in the same cycle.
REQ-023 State machine states: IDLE (queue empty), BURST (head beat is not the last), LAST (head beat is the last).
REQ-024 IDLE SHALL move on push to LAST if len=0, otherwise to BURST.
REQ-025 BURST SHALL hold when no handshake occurs; on handshake it increments the beat counter and moves to LAST when the new counter value equals head len.
REQ-026 LAST SHALL hold when no handshake occurs; on handshake it pops the head and clears the beat counter.
REQ-026a After that pop, LAST SHALL go to IDLE if no entry remains.
REQ-026b Otherwise LAST SHALL go to LAST or BURST, chosen by the new head's len, where the new head includes an entry pushed in the same cycle.
REQ-027 rvalid SHALL be high exactly in BURST and LAST; rlast SHALL be high exactly in LAST.
REQ-028 rdata SHALL equal the head data slice [beat_cntr*DW +: DW]; rid and rresp SHALL equal the head fields.
REQ-029 While rvalid is low, rdata, rid, rresp and rlast SHALL be 0.
REQ-030 Latency: a push into an empty queue SHALL raise rvalid on the next cycle.
REQ-031 rvalid SHALL fall only when the last queued burst completes; rdata, rid, rresp and rlast SHALL stay stable while rvalid is high and rready is low.
REQ-032 A push and a pop in the same cycle SHALL leave the entry count unchanged; queue pointers SHALL wrap modulo QDEPTH.
REQ-033 Back-to-back bursts SHALL complete with no idle cycle between them when the next entry is already queued.
REQ-034 finish_rdata_s SHALL be registered, going high for exactly one cycle after each LAST handshake.
REQ-035 The block SHALL NOT reorder bursts; output order equals push order.

Reset
REQ-036 While rst is high at a clk edge: state IDLE, queue empty with pointers and count 0, beat counter 0.
REQ-037 After such a reset edge: rvalid=0, rlast=0, rdata=0, rid=0, rresp=0, finish_rdata_s=0, rdata_s_ready=1.
REQ-038 Reset mid-burst SHALL discard all queued and partly sent bursts; no finish pulse SHALL be generated for them.

Verification
REQ-039 Push id=3, len=3, resp=0, data={32'hD,32'hC,32'hB,32'hA}; hold rready=1 -> beats A,B,C,D on 4 consecutive cycles, rid=3, rlast only on D, finish_rdata_s one cycle after D.
REQ-040 Push len=0, id=5, resp=2 -> a single beat with rlast=1 and rresp=2, then one finish pulse.
REQ-041 Hold rready=0 for 3 cycles mid-burst -> beat data, rid and rlast stable, counter held; the burst then resumes.
REQ-042 With QDEPTH=2, push 3 lines while rready=0 -> rdata_s_ready=0 after the second push; the third push is accepted the cycle after the first burst's LAST handshake.
REQ-043 Two queued bursts (id 1, len 1; id 2, len 3) with rready=1 -> 6 contiguous beats, rlast on beats 2 and 6, two finish pulses.
REQ-044 Assert rst during beat 2 of a 4-beat burst -> next cycle rvalid=0, rdata=0, no finish pulse; a new push afterwards is sent from beat 0.

Source files
------------

// File: rtl/rdata_chan_subo_burst.sv
// Read-data channel burst serializer. Queues whole lines from a source
// and plays each one out as a burst of DW-wide beats with rlast on the
// final beat. A registered finish pulse follows each completed burst.
module rdata_chan_subo_burst #(
    parameter int unsigned DW     = 32,
    parameter int unsigned BEATS  = 4,
    parameter int unsigned IDW    = 4,
    parameter int unsigned QDEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [IDW-1:0]             rid,
    output logic [DW-1:0]              rdata,
    output logic [1:0]                 rresp,
    output logic                       rlast,
    input  logic                       rdata_s_valid,
    output logic                       rdata_s_ready,
    input  logic [IDW-1:0]             rdata_s_id,
    input  logic [DW*BEATS-1:0]        rdata_s_data,
    input  logic [$clog2(BEATS)-1:0]   rdata_s_len,
    input  logic [1:0]                 rdata_s_resp,
    output logic                       finish_rdata_s
);

    localparam int unsigned LW = $clog2(BEATS);
    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [IDW-1:0]      id;
        logic [DW*BEATS-1:0] data;
        logic [LW-1:0]       len;
        logic [1:0]          resp;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_LAST  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    entry_t         mem_q [QDEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [LW-1:0]  beat_q, beat_d;
    logic           finish_q;

    entry_t         head;
    logic           push, hs, pop;
    logic [LW-1:0]  beat_inc;
    logic [LW-1:0]  next_head_len;
    logic           empty_after_pop;

    // Pointer advance that wraps at QDEPTH, which need not be a power of 2.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : PW'(p + PW'(1));
    endfunction

    // Handshakes and the head entry the outputs are built from.
    always_comb begin
        head            = mem_q[rd_ptr_q];
        rdata_s_ready   = (count_q < CW'(QDEPTH));
        push            = rdata_s_valid && rdata_s_ready;
        hs              = (state_q != S_IDLE) && rready;
        pop             = hs && (state_q == S_LAST);
        beat_inc        = LW'(beat_q + LW'(1));
        // After a pop the new head is either the next stored entry or, when
        // only one entry was queued, the line being pushed this same cycle.
        next_head_len   = (count_q > CW'(1)) ? mem_q[ptr_inc(rd_ptr_q)].len : rdata_s_len;
        empty_after_pop = (count_q == CW'(1)) && !push;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and beat-counter logic.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_IDLE: begin
                if (push) begin
                    state_d = (rdata_s_len == '0) ? S_LAST : S_BURST;
                end
            end
            S_BURST: begin
                if (hs) begin
                    beat_d = beat_inc;
                    if (beat_inc == head.len) begin
                        state_d = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (hs) begin
                    beat_d = '0;
                    if (empty_after_pop) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = (next_head_len == '0) ? S_LAST : S_BURST;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Output decode; beat fields are forced to zero while no beat is offered.
    always_comb begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rid    = '0;
        rdata  = '0;
        rresp  = '0;
        if (state_q != S_IDLE) begin
            rvalid = 1'b1;
            rlast  = (state_q == S_LAST);
            rid    = head.id;
            rdata  = head.data[beat_q*DW +: DW];
            rresp  = head.resp;
        end
    end

    // Queue pointers, occupancy, beat counter and the finish pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            finish_q <= 1'b0;
        end else begin
            beat_q   <= beat_d;
            finish_q <= pop;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= CW'(count_q + CW'(1));
                2'b01:   count_q <= CW'(count_q - CW'(1));
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{id: rdata_s_id, data: rdata_s_data,
                                 len: rdata_s_len, resp: rdata_s_resp};
        end
    end

    assign finish_rdata_s = finish_q;

endmodule

// File: tb/tb_rdata_chan_subo_burst.sv
// Directed bench for rdata_chan_subo_burst with hand-computed expectations.
module tb_rdata_chan_subo_burst;

    localparam int unsigned DW     = 32;
    localparam int unsigned BEATS  = 4;
    localparam int unsigned IDW    = 4;
    localparam int unsigned QDEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   rvalid;
    logic                   rready;
    logic [IDW-1:0]         rid;
    logic [DW-1:0]          rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   rdata_s_valid;
    logic                   rdata_s_ready;
    logic [IDW-1:0]         rdata_s_id;
    logic [DW*BEATS-1:0]    rdata_s_data;
    logic [1:0]             rdata_s_len;
    logic [1:0]             rdata_s_resp;
    logic                   finish_rdata_s;

    int n_cmp  = 0;
    int n_fail = 0;

    rdata_chan_subo_burst #(
        .DW(DW), .BEATS(BEATS), .IDW(IDW), .QDEPTH(QDEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rvalid         (rvalid),
        .rready         (rready),
        .rid            (rid),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast),
        .rdata_s_valid  (rdata_s_valid),
        .rdata_s_ready  (rdata_s_ready),
        .rdata_s_id     (rdata_s_id),
        .rdata_s_data   (rdata_s_data),
        .rdata_s_len    (rdata_s_len),
        .rdata_s_resp   (rdata_s_resp),
        .finish_rdata_s (finish_rdata_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [IDW-1:0] id, input logic [1:0] len,
                         input logic [1:0] resp, input logic [DW*BEATS-1:0] data);
        rdata_s_valid = 1'b1;
        rdata_s_id    = id;
        rdata_s_len   = len;
        rdata_s_resp  = resp;
        rdata_s_data  = data;
    endtask

    task automatic beat(input string tag, input logic v, input logic [IDW-1:0] id,
                        input logic [DW-1:0] d, input logic l, input logic f);
        chk({tag, ".rvalid"}, 64'(rvalid), 64'(v));
        chk({tag, ".rid"},    64'(rid),    64'(id));
        chk({tag, ".rdata"},  64'(rdata),  64'(d));
        chk({tag, ".rlast"},  64'(rlast),  64'(l));
        chk({tag, ".finish"}, 64'(finish_rdata_s), 64'(f));
    endtask

    initial begin
        rst           = 1'b1;
        rready        = 1'b0;
        rdata_s_valid = 1'b0;
        rdata_s_id    = '0;
        rdata_s_data  = '0;
        rdata_s_len   = '0;
        rdata_s_resp  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst.rvalid", 64'(rvalid), 64'd0);
        chk("rst.rlast",  64'(rlast),  64'd0);
        chk("rst.rdata",  64'(rdata),  64'd0);
        chk("rst.rid",    64'(rid),    64'd0);
        chk("rst.rresp",  64'(rresp),  64'd0);
        chk("rst.finish", 64'(finish_rdata_s), 64'd0);
        chk("rst.ready",  64'(rdata_s_ready),  64'd1);

        // Four-beat burst with rready held high
        offer(4'd3, 2'd3, 2'd0, {32'hD, 32'hC, 32'hB, 32'hA});
        rready = 1'b1;
        tick();
        rdata_s_valid = 1'b0;
        beat("b4.0", 1'b1, 4'd3, 32'hA, 1'b0, 1'b0);
        chk("b4.rresp", 64'(rresp), 64'd0);
        tick(); beat("b4.1", 1'b1, 4'd3, 32'hB, 1'b0, 1'b0);
        tick(); beat("b4.2", 1'b1, 4'd3, 32'hC, 1'b0, 1'b0);
        tick(); beat("b4.3", 1'b1, 4'd3, 32'hD, 1'b1, 1'b0);
        tick(); beat("b4.fin", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        tick(); chk("b4.fin_off", 64'(finish_rdata_s), 64'd0);

        // Single-beat burst with error response
        offer(4'd5, 2'd0, 2'd2, {32'h0, 32'h0, 32'h0, 32'h55});
        tick();
        rdata_s_valid = 1'b0;
        beat("b1.0", 1'b1, 4'd5, 32'h55, 1'b1, 1'b0);
        chk("b1.rresp", 64'(rresp), 64'd2);
        tick();
        beat("b1.fin", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        chk("b1.rresp_off", 64'(rresp), 64'd0);
        tick(); chk("b1.fin_off", 64'(finish_rdata_s), 64'd0);

        // Backpressure stall mid-burst
        offer(4'd7, 2'd3, 2'd1, {32'h44, 32'h33, 32'h22, 32'h11});
        tick();
        rdata_s_valid = 1'b0;
        beat("st.0", 1'b1, 4'd7, 32'h11, 1'b0, 1'b0);
        tick();
        beat("st.1", 1'b1, 4'd7, 32'h22, 1'b0, 1'b0);
        rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            beat("st.hold", 1'b1, 4'd7, 32'h22, 1'b0, 1'b0);
            chk("st.rresp", 64'(rresp), 64'd1);
        end
        rready = 1'b1;
        tick(); beat("st.2", 1'b1, 4'd7, 32'h33, 1'b0, 1'b0);
        tick(); beat("st.3", 1'b1, 4'd7, 32'h44, 1'b1, 1'b0);
        tick(); beat("st.fin", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);

        // Queue full: three lines offered while rready is low
        rready = 1'b0;
        offer(4'd1, 2'd1, 2'd0, {32'h0, 32'h0, 32'h112, 32'h111});
        tick();
        chk("qf.ready1", 64'(rdata_s_ready), 64'd1);
        offer(4'd2, 2'd0, 2'd0, {32'h0, 32'h0, 32'h0, 32'h221});
        tick();
        chk("qf.ready2", 64'(rdata_s_ready), 64'd0);
        offer(4'd3, 2'd0, 2'd3, {32'h0, 32'h0, 32'h0, 32'h331});
        tick();
        chk("qf.ready3", 64'(rdata_s_ready), 64'd0);
        beat("qf.h0", 1'b1, 4'd1, 32'h111, 1'b0, 1'b0);
        rready = 1'b1;
        tick();
        beat("qf.h1", 1'b1, 4'd1, 32'h112, 1'b1, 1'b0);
        chk("qf.ready4", 64'(rdata_s_ready), 64'd0);
        tick();
        beat("qf.l2", 1'b1, 4'd2, 32'h221, 1'b1, 1'b1);
        chk("qf.ready5", 64'(rdata_s_ready), 64'd1);
        tick();
        rdata_s_valid = 1'b0;
        beat("qf.l3", 1'b1, 4'd3, 32'h331, 1'b1, 1'b1);
        chk("qf.l3resp", 64'(rresp), 64'd3);
        tick();
        beat("qf.fin", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);

        // Two queued bursts played back to back
        rready = 1'b0;
        offer(4'd1, 2'd1, 2'd0, {32'h0, 32'h0, 32'hA1, 32'hA0});
        tick();
        offer(4'd2, 2'd3, 2'd0, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        tick();
        rdata_s_valid = 1'b0;
        rready = 1'b1;
        beat("bb.1", 1'b1, 4'd1, 32'hA0, 1'b0, 1'b0);
        tick(); beat("bb.2", 1'b1, 4'd1, 32'hA1, 1'b1, 1'b0);
        tick(); beat("bb.3", 1'b1, 4'd2, 32'hB0, 1'b0, 1'b1);
        tick(); beat("bb.4", 1'b1, 4'd2, 32'hB1, 1'b0, 1'b0);
        tick(); beat("bb.5", 1'b1, 4'd2, 32'hB2, 1'b0, 1'b0);
        tick(); beat("bb.6", 1'b1, 4'd2, 32'hB3, 1'b1, 1'b0);
        tick(); beat("bb.fin", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);

        // Reset in the middle of a burst
        offer(4'd9, 2'd3, 2'd0, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        tick();
        rdata_s_valid = 1'b0;
        beat("mr.0", 1'b1, 4'd9, 32'hD0, 1'b0, 1'b0);
        tick(); beat("mr.1", 1'b1, 4'd9, 32'hD1, 1'b0, 1'b0);
        tick(); beat("mr.2", 1'b1, 4'd9, 32'hD2, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        beat("mr.rst", 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        chk("mr.ready", 64'(rdata_s_ready), 64'd1);
        tick();
        chk("mr.nofin", 64'(finish_rdata_s), 64'd0);
        offer(4'd4, 2'd1, 2'd0, {32'h0, 32'h0, 32'hF1, 32'hF0});
        tick();
        rdata_s_valid = 1'b0;
        beat("mr.n0", 1'b1, 4'd4, 32'hF0, 1'b0, 1'b0);
        tick(); beat("mr.n1", 1'b1, 4'd4, 32'hF1, 1'b1, 1'b0);
        tick(); beat("mr.fin", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
